// File: rtl/cracker_pkg.sv
// Shared definitions for the password cracker: FSM encoding, character-set defaults,
// length-field width and start-parameter validation used by every cracker block.
package cracker_pkg;

    localparam logic [7:0] DEF_CHAR_FIRST = 8'h20;
    localparam logic [7:0] DEF_CHAR_LAST  = 8'h7E;
    localparam int         DEF_MAX_CHARS  = 20;
    localparam int         LEN_W          = 5;
    localparam int         INDEX_W        = 48;

    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EMIT = 2'b01,
        ST_DONE = 2'b10
    } enum_state_t;

    // A length range is usable when it is non-empty, starts at 1 and fits the buffer.
    function automatic logic lengths_ok(input len_t min_len, input len_t max_len,
                                        input int max_chars);
        return (min_len != {LEN_W{1'b0}}) && (min_len <= max_len) &&
               (int'(max_len) <= max_chars);
    endfunction

endpackage

// File: rtl/odometer_digit.sv
// One character position of the enumeration odometer: wraps CHAR_LAST -> CHAR_FIRST
// and reports a carry when incremented at CHAR_LAST.
module odometer_digit #(
    parameter logic [7:0] CHAR_FIRST = 8'h20,
    parameter logic [7:0] CHAR_LAST  = 8'h7E
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       reload,
    input  logic       inc_en,
    output logic [7:0] value,
    output logic       at_last,
    output logic       carry_out
);
    logic [7:0] value_r;

    // Character register: clear beats reload beats increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_r <= 8'h00;
        end else if (clear) begin
            value_r <= 8'h00;
        end else if (reload) begin
            value_r <= CHAR_FIRST;
        end else if (inc_en) begin
            value_r <= (value_r == CHAR_LAST) ? CHAR_FIRST : value_r + 8'd1;
        end else begin
            value_r <= value_r;
        end
    end

    assign value     = value_r;
    assign at_last   = (value_r == CHAR_LAST);
    assign carry_out = inc_en && at_last;

endmodule

// File: rtl/password_enumerator.sv
// Password candidate enumerator: walks every string over [CHAR_FIRST, CHAR_LAST] from
// min_length to max_length, char[0] fastest, one candidate per valid/ready handshake.
module password_enumerator
    import cracker_pkg::*;
#(
    parameter logic [7:0] CHAR_FIRST = DEF_CHAR_FIRST,
    parameter logic [7:0] CHAR_LAST  = DEF_CHAR_LAST,
    parameter int         MAX_CHARS  = DEF_MAX_CHARS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [4:0]             min_length,
    input  logic [4:0]             max_length,
    input  logic                   cand_ready,
    output logic                   cand_valid,
    output logic [8*MAX_CHARS-1:0] cand_password,
    output logic [4:0]             cand_length,
    output logic                   busy,
    output logic                   exhausted,
    output logic                   param_error,
    output logic [47:0]            cand_index
);
    enum_state_t          state_r;
    enum_state_t          state_nxt_s;
    len_t                 len_r;
    len_t                 max_len_r;
    logic [INDEX_W-1:0]   idx_r;
    logic                 valid_r;
    logic                 exh_r;
    logic                 perr_r;
    logic                 hs_s;
    logic                 top_carry_s;
    logic                 load_s;
    logic                 perr_s;
    logic                 grow_s;
    logic                 finish_s;
    logic [MAX_CHARS-1:0] inc_en_s;
    logic [MAX_CHARS-1:0] carry_s;
    logic [MAX_CHARS-1:0] at_last_s;
    logic [MAX_CHARS-1:0] clear_s;
    logic [MAX_CHARS-1:0] reload_s;

    // Abort overrides any handshake, so no advance happens on an aborting edge.
    assign hs_s = (state_r == ST_EMIT) && cand_ready && !abort;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        perr_s      = 1'b0;
        grow_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    if (lengths_ok(min_length, max_length, MAX_CHARS)) begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_EMIT;
                    end else begin
                        perr_s      = 1'b1;
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_EMIT: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (hs_s && top_carry_s) begin
                    if (len_r < max_len_r) begin
                        grow_s = 1'b1;
                    end else begin
                        finish_s    = 1'b1;
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Increment enables: position i steps when every lower active position sits at CHAR_LAST.
    always_comb begin
        logic run_v;
        run_v    = 1'b1;
        inc_en_s = {MAX_CHARS{1'b0}};
        for (int i = 0; i < MAX_CHARS; i++) begin
            inc_en_s[i] = hs_s && run_v && (i < int'(len_r));
            run_v       = run_v && at_last_s[i];
        end
    end

    // Carry leaving the most significant active position.
    always_comb begin
        top_carry_s = 1'b0;
        for (int i = 0; i < MAX_CHARS; i++) begin
            top_carry_s = top_carry_s | ((i == int'(len_r) - 1) && carry_s[i]);
        end
    end

    // Reload/clear: a start fills 0..min-1 and zeroes the rest; a length step refills 0..len.
    always_comb begin
        clear_s  = {MAX_CHARS{1'b0}};
        reload_s = {MAX_CHARS{1'b0}};
        for (int i = 0; i < MAX_CHARS; i++) begin
            clear_s[i]  = load_s && !(i < int'(min_length));
            reload_s[i] = (load_s && (i < int'(min_length))) ||
                          (grow_s && (i <= int'(len_r)));
        end
    end

    for (genvar g = 0; g < MAX_CHARS; g++) begin : g_digit
        odometer_digit #(
            .CHAR_FIRST (CHAR_FIRST),
            .CHAR_LAST  (CHAR_LAST)
        ) u_digit (
            .clk        (clk),
            .reset_n    (reset_n),
            .clear      (clear_s[g]),
            .reload     (reload_s[g]),
            .inc_en     (inc_en_s[g]),
            .value      (cand_password[8*g +: 8]),
            .at_last    (at_last_s[g]),
            .carry_out  (carry_s[g])
        );
    end

    // Length, index and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_r     <= {LEN_W{1'b0}};
            max_len_r <= {LEN_W{1'b0}};
            idx_r     <= {INDEX_W{1'b0}};
            valid_r   <= 1'b0;
            exh_r     <= 1'b0;
            perr_r    <= 1'b0;
        end else begin
            valid_r <= (state_nxt_s == ST_EMIT);
            if (load_s) begin
                len_r     <= min_length;
                max_len_r <= max_length;
                idx_r     <= {INDEX_W{1'b0}};
                exh_r     <= 1'b0;
                perr_r    <= 1'b0;
            end else if (perr_s) begin
                exh_r  <= 1'b0;
                perr_r <= 1'b1;
            end else if (hs_s) begin
                idx_r <= idx_r + 48'd1;
                len_r <= grow_s ? len_r + 5'd1 : len_r;
                exh_r <= exh_r | finish_s;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    assign cand_valid  = valid_r;
    assign busy        = valid_r;
    assign cand_length = len_r;
    assign cand_index  = idx_r;
    assign exhausted   = exh_r;
    assign param_error = perr_r;

endmodule

// File: tb/tb_password_enumerator.sv
// Bench for password_enumerator: a candidate-number model checked every cycle, plus
// directed scenarios with literal expectations; a second instance uses a binary charset.
module tb_password_enumerator;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         abort;
    logic [4:0]   min_length;
    logic [4:0]   max_length;
    logic         cand_ready;
    logic         cand_valid;
    logic [159:0] cand_password;
    logic [4:0]   cand_length;
    logic         busy;
    logic         exhausted;
    logic         param_error;
    logic [47:0]  cand_index;

    logic         start_b;
    logic         cand_valid_b;
    logic [159:0] cand_password_b;
    logic [4:0]   cand_length_b;
    logic         busy_b;
    logic         exhausted_b;
    logic         param_error_b;
    logic [47:0]  cand_index_b;

    int n_checks;
    int n_fail;

    // model of the primary instance
    int     m_state;   // 0 idle, 1 emit, 2 done
    longint m_k;
    longint m_total;
    int     m_min;
    logic   m_exh;
    logic   m_perr;

    password_enumerator dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .min_length    (min_length),
        .max_length    (max_length),
        .cand_ready    (cand_ready),
        .cand_valid    (cand_valid),
        .cand_password (cand_password),
        .cand_length   (cand_length),
        .busy          (busy),
        .exhausted     (exhausted),
        .param_error   (param_error),
        .cand_index    (cand_index)
    );

    password_enumerator #(
        .CHAR_FIRST (8'h30),
        .CHAR_LAST  (8'h31),
        .MAX_CHARS  (20)
    ) dut_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start_b),
        .abort         (1'b0),
        .min_length    (5'd6),
        .max_length    (5'd6),
        .cand_ready    (1'b1),
        .cand_valid    (cand_valid_b),
        .cand_password (cand_password_b),
        .cand_length   (cand_length_b),
        .busy          (busy_b),
        .exhausted     (exhausted_b),
        .param_error   (param_error_b),
        .cand_index    (cand_index_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_start(input int mn, input int mx);
        min_length = 5'(mn);
        max_length = 5'(mx);
        start      = 1'b1;
        step(1);
        start      = 1'b0;
    endtask

    // Number of strings with lengths mn..mx over an n-letter alphabet.
    function automatic longint total_count(input int n, input int mn, input int mx);
        longint t;
        longint p;
        t = 0;
        p = 1;
        for (int len = 1; len <= mx; len++) begin
            if (p < 64'sd1099511627776) p = p * n;
            if (len >= mn) t = t + p;
        end
        return t;
    endfunction

    // Length of the k-th candidate (k counted from 0 since start).
    function automatic int exp_len(input int n, input int mn, input longint k);
        longint p;
        int     len;
        p   = 1;
        len = mn;
        for (int i = 0; i < mn; i++) p = p * n;
        while (k >= p && len < 20) begin
            k   = k - p;
            len = len + 1;
            p   = p * n;
        end
        return len;
    endfunction

    // Characters of the k-th candidate: k's offset within its length, base n, digit 0 first.
    function automatic logic [159:0] exp_pw(input int cf, input int n, input int mn, input longint k);
        logic [159:0] pw;
        longint p;
        int     len;
        p   = 1;
        len = mn;
        for (int i = 0; i < mn; i++) p = p * n;
        while (k >= p && len < 20) begin
            k   = k - p;
            len = len + 1;
            p   = p * n;
        end
        pw = 160'h0;
        for (int i = 0; i < len; i++) begin
            pw[8*i +: 8] = 8'(cf + int'(k % n));
            k = k / n;
        end
        return pw;
    endfunction

    // Behavioural model of the primary instance, stepped on each clock edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state <= 0;
            m_k     <= 0;
            m_total <= 0;
            m_min   <= 0;
            m_exh   <= 1'b0;
            m_perr  <= 1'b0;
        end else if (m_state == 1) begin
            if (abort) begin
                m_state <= 0;
            end else if (cand_ready) begin
                m_k <= m_k + 1;
                if (m_k + 1 == m_total) begin
                    m_state <= 2;
                    m_exh   <= 1'b1;
                end
            end
        end else if (abort) begin
            m_state <= 0;
        end else if (start) begin
            if (min_length >= 5'd1 && min_length <= max_length && max_length <= 5'd20) begin
                m_state <= 1;
                m_k     <= 0;
                m_min   <= int'(min_length);
                m_total <= total_count(95, int'(min_length), int'(max_length));
                m_exh   <= 1'b0;
                m_perr  <= 1'b0;
            end else begin
                m_state <= 2;
                m_exh   <= 1'b0;
                m_perr  <= 1'b1;
            end
        end
    end

    // Per-cycle comparison of the primary instance against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("cand_valid", {159'h0, cand_valid}, {159'h0, m_state == 1});
            chk("busy", {159'h0, busy}, {159'h0, m_state == 1});
            chk("exhausted", {159'h0, exhausted}, {159'h0, m_exh});
            chk("param_error", {159'h0, param_error}, {159'h0, m_perr});
            if (m_state == 1) begin
                chk("cand_index", {112'h0, cand_index}, {112'h0, 48'(m_k)});
                chk("cand_length", {155'h0, cand_length}, {155'h0, 5'(exp_len(95, m_min, m_k))});
                chk("cand_password", cand_password, exp_pw(32, 95, m_min, m_k));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int held;
        logic seen95;
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        min_length = 5'd0;
        max_length = 5'd0;
        cand_ready = 1'b0;
        start_b    = 1'b0;
        step(2);
        chk("reset_valid", {159'h0, cand_valid}, 160'h0);
        chk("reset_index", {112'h0, cand_index}, 160'h0);
        chk("reset_pw", cand_password, 160'h0);
        chk("reset_len", {155'h0, cand_length}, 160'h0);
        reset_n = 1'b1;
        step(1);

        // length 1 only, with a 3-cycle stall on candidate 5
        cand_ready = 1'b1;
        do_start(1, 1);
        chk("first_pw", cand_password, 160'h20);
        chk("first_len", {155'h0, cand_length}, 160'd1);
        chk("first_idx", {112'h0, cand_index}, 160'd0);
        held = 0;
        for (int c = 0; c < 400 && !exhausted; c++) begin
            if (m_k == 5 && held < 3 && cand_valid) begin
                chk("stall_pw", cand_password, 160'h25);
                chk("stall_idx", {112'h0, cand_index}, 160'd5);
                cand_ready = 1'b0;
                held++;
            end else begin
                cand_ready = 1'b1;
            end
            step(1);
        end
        chk("a_exhausted", {159'h0, exhausted}, 160'h1);
        chk("a_valid_end", {159'h0, cand_valid}, 160'h0);
        chk("a_index_end", {112'h0, cand_index}, 160'd95);

        // lengths 1..2, with a start pulse that must be ignored mid-run
        cand_ready = 1'b1;
        do_start(1, 2);
        seen95 = 1'b0;
        for (int c = 0; c < 12000 && !exhausted; c++) begin
            if (m_k == 95 && !seen95) begin
                chk("grow_len", {155'h0, cand_length}, 160'd2);
                chk("grow_pw", cand_password, 160'h2020);
                seen95 = 1'b1;
            end
            if (m_k == 50) begin
                min_length = 5'd1;
                max_length = 5'd1;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            step(1);
        end
        chk("b_exhausted", {159'h0, exhausted}, 160'h1);
        chk("b_index_end", {112'h0, cand_index}, 160'd9120);

        // invalid length ranges
        do_start(0, 5);
        step(1);
        chk("perr_min0", {159'h0, param_error}, 160'h1);
        chk("perr_min0_valid", {159'h0, cand_valid}, 160'h0);
        do_start(3, 2);
        step(1);
        chk("perr_minmax", {159'h0, param_error}, 160'h1);
        chk("perr_minmax_busy", {159'h0, busy}, 160'h0);
        do_start(1, 21);
        step(1);
        chk("perr_max21", {159'h0, param_error}, 160'h1);
        chk("perr_max21_valid", {159'h0, cand_valid}, 160'h0);

        // abort at index 10, together with start and a handshake
        do_start(1, 2);
        for (int c = 0; c < 50 && m_k != 10; c++) step(1);
        chk("abort_at_idx", {112'h0, cand_index}, 160'd10);
        abort = 1'b1;
        start = 1'b1;
        step(1);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_valid", {159'h0, cand_valid}, 160'h0);
        chk("abort_busy", {159'h0, busy}, 160'h0);
        step(2);

        // asynchronous reset in the middle of EMIT
        do_start(1, 2);
        step(7);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {159'h0, cand_valid}, 160'h0);
        chk("arst_busy", {159'h0, busy}, 160'h0);
        chk("arst_index", {112'h0, cand_index}, 160'h0);
        chk("arst_pw", cand_password, 160'h0);
        chk("arst_len", {155'h0, cand_length}, 160'h0);
        step(2);
        reset_n = 1'b1;
        do_start(1, 1);
        chk("post_rst_pw", cand_password, 160'h20);
        chk("post_rst_valid", {159'h0, cand_valid}, 160'h1);
        step(100);

        // binary charset '0'/'1', exactly six characters
        start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        for (int k = 0; k < 64; k++) begin
            chk("b6_valid", {159'h0, cand_valid_b}, 160'h1);
            chk("b6_index", {112'h0, cand_index_b}, 160'(k));
            chk("b6_len", {155'h0, cand_length_b}, 160'd6);
            chk("b6_pw", cand_password_b, exp_pw(48, 2, 6, longint'(k)));
            if (k == 0) chk("b6_first", cand_password_b, 160'h303030303030);
            if (k == 63) chk("b6_last", cand_password_b, 160'h313131313131);
            step(1);
        end
        chk("b6_exhausted", {159'h0, exhausted_b}, 160'h1);
        chk("b6_valid_end", {159'h0, cand_valid_b}, 160'h0);
        chk("b6_perr", {159'h0, param_error_b}, 160'h0);
        chk("b6_busy_end", {159'h0, busy_b}, 160'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
